hdu_scoreboard: RTL and testbench
=================================

Name: hdu_scoreboard

Overview:
Parametrised hazard detection unit for the in-order RV32I pipeline. It replaces per-stage rd comparison with a per-register scoreboard.
- Fixed-latency producers are tracked by countdown counters.
- Variable-latency producers (MUL/DIV unit) are tracked by a long-pending bit.
- The unit generates stall, bubble and flush controls for the pipeline registers, and keeps stall/flush performance counters.

Parameters:
NUM_REGS, 32, architectural register count; register index width is $clog2(NUM_REGS).
CNT_W, 3, width of each latency countdown counter and of i_lat_id.
PERF_W, 32, width of the performance counters.

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_instr_id  in  32  instruction currently in ID.
i_id_valid  in  1  ID holds a real (non-bubble) instruction.
i_rd_wren_id  in  1  ID instruction writes rd.
i_long_id  in  1  ID instruction is a variable-latency (MUL/DIV) op.
i_lat_id  in  CNT_W  cycles ID must wait before reading a result from a fixed-latency op (0 = no tracking).
i_long_done  in  1  long unit writes back its result this cycle.
i_long_rd  in  5  destination register of the completing long op.
i_branch_taken  in  1  EX resolved a taken branch or jump (control hazard).
o_stall  out  1  hold PC, IF/ID.
o_bubble_ex  out  1  load a NOP into ID/EX.
o_flush_if  out  1  clear IF/ID.
o_flush_id  out  1  clear ID/EX.
o_issue  out  1  ID instruction advances this cycle.
o_long_busy  out  1  long unit is occupied.
o_stall_cnt  out  PERF_W  count of cycles with o_stall=1.
o_flush_cnt  out  PERF_W  count of flush events.

Behaviour:
Decode fields:
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- uses_rs1: all opcodes except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- uses_rs2: R (0110011), S (0100011) and B (1100011) only.

State per register r: cnt[r] (CNT_W bits) and lng[r] (1 bit). pend[r] = (cnt[r] != 0) | lng[r]. Register 0 is never pending; writes to it are ignored.

raw (read-after-write): (uses_rs1 & rs1 != 0 & pend[rs1]) | (uses_rs2 & rs2 != 0 & pend[rs2]).

struct (structural/ordering hazard), true if either holds:
- i_long_id & o_long_busy & !i_long_done.
- i_rd_wren_id & rd != 0 & lng[rd] (write-after-write against an outstanding long op).

hazard = i_id_valid & (raw | struct).

Output priority:
1. i_branch_taken: o_flush_if = o_flush_id = 1, o_stall = o_bubble_ex = 0, o_issue = 0.
2. Else if hazard: o_stall = o_bubble_ex = 1, o_issue = 0.
3. Else: o_issue = i_id_valid; all other controls 0.

Same-cycle completion:
- pend is evaluated on registered state; a register whose cnt reaches 0 this cycle is visible as free next cycle.
- i_long_done bypasses lng: if i_long_done and i_long_rd == rs1 or rs2, that source is treated as not pending this cycle (result written to the write-first register file).

Sequential update (every rising edge, non-reset):
- Every cnt[r] != 0 decrements by 1.
- If i_long_done: lng[i_long_rd] <= 0, busy <= 0.
- If o_issue & i_rd_wren_id & rd != 0:
  - If i_long_id: lng[rd] <= 1, busy <= 1. Long set wins over a same-cycle done for the same rd.
  - Else: cnt[rd] <= i_lat_id. The load overrides the decrement.
- A flushed or stalled ID instruction never updates the scoreboard.
- Entries owned by older in-flight instructions are not cleared on flush.

Performance counters:
- o_stall_cnt += 1 on each cycle with o_stall = 1.
- o_flush_cnt += 1 on each cycle with i_branch_taken = 1.
- Both saturate at all-ones.

Reset (synchronous, active-high):
- All cnt, lng, busy and performance counters clear to 0.
- While i_reset = 1: o_flush_if = o_flush_id = 1, o_stall = o_bubble_ex = o_issue = 0, o_long_busy = 0.
- Reset mid long op discards it; a later i_long_done with no entry is harmless.

Latency: all controls are combinational from inputs and registered state. The scoreboard updates one edge after issue.

Test Plan:
1. ADD x5,x1,x2 (lat 3) issued, then ADD x6,x5,x0 in ID -> o_stall=1 for exactly 3 cycles, issue on 4th; o_stall_cnt=3.
2. ADDI x0 with lat 3, then a read of x0; separately LUI x7 after a pending x7's rs1 field -> no stall in either case.
3. DIV x8 (long), then ADD x9,x8,x1 -> stall until the i_long_done(rd=8) cycle, issue in that same cycle; o_long_busy drops the next edge.
4. A second MUL while busy -> stalled; with i_long_done asserted the same cycle -> issues; busy stays 1.
5. Data hazard and i_branch_taken in the same cycle -> flush_if = flush_id = 1, stall = 0, no scoreboard write; o_flush_cnt increments by 1.
6. Reset asserted with cnt[5]=2 and lng[8]=1 -> next cycle nothing pending and a read of x5/x8 issues immediately; force o_stall_cnt near max -> it saturates at 2^PERF_W-1.

Source files
------------

// File: rtl/hdu_scoreboard.sv
// Hazard detection unit built on a per-register scoreboard.
// Fixed-latency producers load a countdown counter for their rd.
// Variable-latency (MUL/DIV) producers set a long-pending bit until the long unit reports completion.
// The unit drives the stall, bubble and flush controls for the pipeline registers.
// It also keeps saturating stall and flush event counters.
module hdu_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instr_id,
    input  logic              i_id_valid,
    input  logic              i_rd_wren_id,
    input  logic              i_long_id,
    input  logic [CNT_W-1:0]  i_lat_id,
    input  logic              i_long_done,
    input  logic [4:0]        i_long_rd,
    input  logic              i_branch_taken,
    output logic              o_stall,
    output logic              o_bubble_ex,
    output logic              o_flush_if,
    output logic              o_flush_id,
    output logic              o_issue,
    output logic              o_long_busy,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    // Scoreboard state; entry 0 is never written, so x0 can never be pending.
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] r_lng;
    logic                r_busy;
    logic [PERF_W-1:0]   r_stall_cnt;
    logic [PERF_W-1:0]   r_flush_cnt;

    logic [6:0]    w_opcode;
    logic [RW-1:0] w_rs1;
    logic [RW-1:0] w_rs2;
    logic [RW-1:0] w_rd;
    logic [RW-1:0] w_long_rd;
    logic          w_uses_rs1;
    logic          w_uses_rs2;
    logic          w_pend_rs1;
    logic          w_pend_rs2;
    logic          w_raw;
    logic          w_struct;
    logic          w_hazard;
    logic          w_sb_write;
    logic          w_unused;

    assign w_opcode  = i_instr_id[6:0];
    assign w_rs1     = i_instr_id[15 +: RW];
    assign w_rs2     = i_instr_id[20 +: RW];
    assign w_rd      = i_instr_id[7 +: RW];
    assign w_long_rd = i_long_rd[RW-1:0];

    // funct3/funct7 play no part in hazard detection.
    assign w_unused = &{1'b0, i_instr_id[31:25], i_instr_id[14:12]};

    assign w_uses_rs1 = !((w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) || (w_opcode == OP_JAL));
    assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_S) || (w_opcode == OP_B);

    // A long op completing this cycle writes a write-first register file, so its lng bit is bypassed.
    assign w_pend_rs1 = (w_rs1 != '0) &&
                        ((r_cnt[w_rs1] != '0) ||
                         (r_lng[w_rs1] && !(i_long_done && (w_long_rd == w_rs1))));
    assign w_pend_rs2 = (w_rs2 != '0) &&
                        ((r_cnt[w_rs2] != '0) ||
                         (r_lng[w_rs2] && !(i_long_done && (w_long_rd == w_rs2))));

    assign w_raw    = (w_uses_rs1 && w_pend_rs1) || (w_uses_rs2 && w_pend_rs2);
    // A second long op waits for the unit; a write to an rd still owed by a long op waits too (WAW).
    assign w_struct = (i_long_id && r_busy && !i_long_done) ||
                      (i_rd_wren_id && (w_rd != '0) && r_lng[w_rd]);
    assign w_hazard = i_id_valid && (w_raw || w_struct);

    assign o_long_busy = r_busy && !i_reset;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Pipeline controls: reset, then taken branch, then hazard, then normal issue.
    always_comb begin
        o_stall     = 1'b0;
        o_bubble_ex = 1'b0;
        o_flush_if  = 1'b0;
        o_flush_id  = 1'b0;
        o_issue     = 1'b0;
        if (i_reset || i_branch_taken) begin
            o_flush_if = 1'b1;
            o_flush_id = 1'b1;
        end else if (w_hazard) begin
            o_stall     = 1'b1;
            o_bubble_ex = 1'b1;
        end else begin
            o_issue = i_id_valid;
        end
    end

    assign w_sb_write = o_issue && i_rd_wren_id && (w_rd != '0);

    // Scoreboard update: count down, retire long ops, then record the issuing instruction (last write wins).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_lng  <= '0;
            r_busy <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                end
            end
            if (i_long_done) begin
                if (w_long_rd != '0) begin
                    r_lng[w_long_rd] <= 1'b0;
                end
                r_busy <= 1'b0;
            end
            if (w_sb_write) begin
                if (i_long_id) begin
                    r_lng[w_rd] <= 1'b1;
                    r_busy      <= 1'b1;
                end else begin
                    r_cnt[w_rd] <= i_lat_id;
                end
            end
        end
    end

    // Saturating stall-cycle and flush-event counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (i_branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Bench for hdu_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with 3-bit counters exposes saturation.
module tb_hdu_scoreboard;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_instr_id = 32'h13;
    logic        i_id_valid = 1'b0;
    logic        i_rd_wren_id = 1'b0;
    logic        i_long_id = 1'b0;
    logic [2:0]  i_lat_id = 3'd0;
    logic        i_long_done = 1'b0;
    logic [4:0]  i_long_rd = 5'd0;
    logic        i_branch_taken = 1'b0;

    logic        o_stall, o_bubble_ex, o_flush_if, o_flush_id, o_issue, o_long_busy;
    logic [31:0] o_stall_cnt, o_flush_cnt;
    logic        s_stall, s_bubble_ex, s_flush_if, s_flush_id, s_issue, s_long_busy;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    logic [5:0]  w_ctl;
    assign w_ctl = {o_flush_if, o_flush_id, o_stall, o_bubble_ex, o_issue, o_long_busy};

    int n_chk = 0;
    int n_pass = 0;

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    hdu_scoreboard u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr_id(i_instr_id), .i_id_valid(i_id_valid),
        .i_rd_wren_id(i_rd_wren_id), .i_long_id(i_long_id), .i_lat_id(i_lat_id),
        .i_long_done(i_long_done), .i_long_rd(i_long_rd), .i_branch_taken(i_branch_taken),
        .o_stall(o_stall), .o_bubble_ex(o_bubble_ex), .o_flush_if(o_flush_if),
        .o_flush_id(o_flush_id), .o_issue(o_issue), .o_long_busy(o_long_busy),
        .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    hdu_scoreboard #(.PERF_W(3)) u_sat (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr_id(i_instr_id), .i_id_valid(i_id_valid),
        .i_rd_wren_id(i_rd_wren_id), .i_long_id(i_long_id), .i_lat_id(i_lat_id),
        .i_long_done(i_long_done), .i_long_rd(i_long_rd), .i_branch_taken(i_branch_taken),
        .o_stall(s_stall), .o_bubble_ex(s_bubble_ex), .o_flush_if(s_flush_if),
        .o_flush_id(s_flush_id), .o_issue(s_issue), .o_long_busy(s_long_busy),
        .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
    );

    // ---------------- encoders ----------------
    function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input int rd, input int rs1);
        return {12'd5, 5'(rs1), 3'b0, 5'(rd), 7'b0010011};
    endfunction

    // LUI whose immediate bits happen to sit where rs1 would be.
    function automatic logic [31:0] lui(input int rd, input int hi5);
        return {12'd0, 5'(hi5), 3'b0, 5'(rd), 7'b0110111};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] instr, input logic valid, input logic wren,
                         input logic lng, input logic [2:0] lat, input logic done,
                         input logic [4:0] lrd, input logic br);
        i_instr_id     = instr;
        i_id_valid     = valid;
        i_rd_wren_id   = wren;
        i_long_id      = lng;
        i_lat_id       = lat;
        i_long_done    = done;
        i_long_rd      = lrd;
        i_branch_taken = br;
    endtask

    task automatic idle;
        drive(32'h13, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        idle;
        tick;
        tick;
        i_reset = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        i_reset = 1'b1;
        drive(r_type(3, 1, 2), 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 5'd0, 1'b0);
        tick;
        #2;
        n_chk++; if (w_ctl !== 6'b110000) $display("FAIL reset_ctl got %b exp 110000", w_ctl); else n_pass++;
        tick;
        i_reset = 1'b0;
        idle;
        #2;
        n_chk++; if (w_ctl !== 6'b000000) $display("FAIL reset_idle_ctl got %b exp 000000", w_ctl); else n_pass++;
        n_chk++;
        if ({o_stall_cnt, o_flush_cnt, s_stall_cnt, s_flush_cnt} !== 70'd0)
            $display("FAIL reset_cnts got %0d %0d %0d %0d exp 0", o_stall_cnt, o_flush_cnt, s_stall_cnt, s_flush_cnt);
        else n_pass++;
        tick;
    endtask

    task automatic test_fixed_latency;
        int n_st;
        do_reset;
        drive(r_type(5, 1, 2), 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000010) $display("FAIL fix_issue_producer got %b exp 000010", w_ctl); else n_pass++;
        tick;
        drive(r_type(6, 5, 0), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        n_st = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (o_issue) break;
            if (o_stall && o_bubble_ex) n_st++;
            tick;
        end
        n_chk++; if (n_st !== 3) $display("FAIL fix_stall_cycles got %0d exp 3", n_st); else n_pass++;
        n_chk++; if (o_issue !== 1'b1) $display("FAIL fix_issue_4th got %b exp 1", o_issue); else n_pass++;
        tick;
        idle;
        #2;
        n_chk++; if (o_stall_cnt !== 32'd3) $display("FAIL fix_stall_cnt got %0d exp 3", o_stall_cnt); else n_pass++;
        tick;
    endtask

    task automatic test_x0_and_lui;
        do_reset;
        drive(i_type(0, 1), 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(9, 0, 0), 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000010) $display("FAIL x0_read got %b exp 000010", w_ctl); else n_pass++;
        tick;
        drive(r_type(7, 1, 2), 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0);
        tick;
        drive(lui(10, 7), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000010) $display("FAIL lui_no_rs1 got %b exp 000010", w_ctl); else n_pass++;
        tick;
        drive(i_type(11, 7), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b001100) $display("FAIL addi_x7_stall got %b exp 001100", w_ctl); else n_pass++;
        tick;
    endtask

    task automatic test_long_op;
        do_reset;
        drive(r_type(8, 1, 2), 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(9, 8, 1), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #2;
            n_chk++; if (w_ctl !== 6'b001101) $display("FAIL long_wait c%0d got %b exp 001101", c, w_ctl); else n_pass++;
            tick;
        end
        i_long_done = 1'b1;
        i_long_rd   = 5'd8;
        #2;
        n_chk++; if (w_ctl !== 6'b000011) $display("FAIL long_done_issue got %b exp 000011", w_ctl); else n_pass++;
        tick;
        idle;
        #2;
        n_chk++; if (w_ctl !== 6'b000000) $display("FAIL long_busy_drop got %b exp 000000", w_ctl); else n_pass++;
        tick;
    endtask

    task automatic test_back_to_back_long;
        do_reset;
        drive(r_type(12, 1, 2), 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(13, 3, 4), 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b001101) $display("FAIL b2b_busy_stall got %b exp 001101", w_ctl); else n_pass++;
        tick;
        drive(r_type(13, 3, 4), 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 5'd12, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000011) $display("FAIL b2b_done_issue got %b exp 000011", w_ctl); else n_pass++;
        tick;
        drive(r_type(14, 13, 0), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b001101) $display("FAIL b2b_busy_kept got %b exp 001101", w_ctl); else n_pass++;
        tick;
        drive(r_type(14, 13, 0), 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 5'd13, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000011) $display("FAIL b2b_second_done got %b exp 000011", w_ctl); else n_pass++;
        tick;
        idle;
        #2;
        n_chk++; if (o_long_busy !== 1'b0) $display("FAIL b2b_idle_busy got %b exp 0", o_long_busy); else n_pass++;
        tick;
    endtask

    task automatic test_branch_flush;
        do_reset;
        drive(r_type(5, 1, 2), 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(6, 5, 0), 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 5'd0, 1'b1);
        #2;
        n_chk++; if (w_ctl !== 6'b110000) $display("FAIL br_flush got %b exp 110000", w_ctl); else n_pass++;
        tick;
        drive(r_type(7, 6, 0), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b000010) $display("FAIL br_no_sb_write got %b exp 000010", w_ctl); else n_pass++;
        n_chk++;
        if ({o_flush_cnt, o_stall_cnt} !== {32'd1, 32'd0})
            $display("FAIL br_cnts got flush %0d stall %0d exp 1 0", o_flush_cnt, o_stall_cnt);
        else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid_and_sat;
        do_reset;
        drive(r_type(5, 1, 2), 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(8, 1, 2), 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(9, 5, 8), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        #2;
        n_chk++; if (w_ctl !== 6'b001101) $display("FAIL rst_pre_stall got %b exp 001101", w_ctl); else n_pass++;
        i_reset = 1'b1;
        #1;
        n_chk++; if (w_ctl !== 6'b110000) $display("FAIL rst_mid_ctl got %b exp 110000", w_ctl); else n_pass++;
        tick;
        i_reset = 1'b0;
        #2;
        n_chk++; if (w_ctl !== 6'b000010) $display("FAIL rst_clear_issue got %b exp 000010", w_ctl); else n_pass++;
        tick;
        idle;
        i_long_done = 1'b1;
        i_long_rd   = 5'd8;
        tick;
        idle;
        #2;
        n_chk++; if (w_ctl !== 6'b000000) $display("FAIL rst_stray_done got %b exp 000000", w_ctl); else n_pass++;
        // Saturation: hold a dependent read behind a long op for 10 cycles.
        do_reset;
        drive(r_type(8, 1, 2), 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 1'b0);
        tick;
        drive(r_type(9, 8, 1), 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 10; c++) tick;
        idle;
        #2;
        n_chk++; if (o_stall_cnt !== 32'd10) $display("FAIL sat_wide_cnt got %0d exp 10", o_stall_cnt); else n_pass++;
        n_chk++; if (s_stall_cnt !== 3'd7) $display("FAIL sat_narrow_cnt got %0d exp 7", s_stall_cnt); else n_pass++;
        tick;
    endtask

    // Randomized traffic checked against a register-level model of the hazard rules.
    task automatic test_random;
        int   m_cnt[32];
        bit   m_lng[32];
        bit   m_busy;
        int   m_stall, m_flush;
        logic [6:0] ops[9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        do_reset;
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_lng[r] = 1'b0;
        end
        m_busy = 1'b0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            logic [5:0] exp_ctl;
            int   rs1, rs2, rd, lrd, lat, exp_ss, exp_sf;
            bit   val, wr, lg, dn, br, rst, u1, u2, p1, p2, raw, st, hz, iss;
            op  = ops[$urandom_range(0, 8)];
            rs1 = $urandom_range(0, 7);
            rs2 = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            val = ($urandom_range(0, 99) < 85);
            wr  = (op != 7'b0100011) && (op != 7'b1100011) && ($urandom_range(0, 7) != 0);
            lg  = (op == 7'b0110011) && ($urandom_range(0, 3) == 0);
            lat = $urandom_range(0, 4);
            dn  = 1'b0;
            lrd = $urandom_range(0, 31);
            if (m_busy) begin
                if ($urandom_range(0, 2) == 0) begin
                    dn = 1'b1;
                    for (int r = 1; r < 32; r++) if (m_lng[r]) lrd = r;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                dn = 1'b1;
            end
            br  = ($urandom_range(0, 99) < 6);
            rst = ($urandom_range(0, 99) < 1);
            i_reset = rst;
            drive({7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op}, val, wr, lg, 3'(lat), dn, 5'(lrd), br);

            u1  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
            u2  = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
            p1  = (rs1 != 0) && ((m_cnt[rs1] > 0) || (m_lng[rs1] && !(dn && lrd == rs1)));
            p2  = (rs2 != 0) && ((m_cnt[rs2] > 0) || (m_lng[rs2] && !(dn && lrd == rs2)));
            raw = (u1 && p1) || (u2 && p2);
            st  = (lg && m_busy && !dn) || (wr && rd != 0 && m_lng[rd]);
            hz  = val && (raw || st);
            iss = !rst && !br && !hz && val;
            if (rst || br) exp_ctl = 6'b110000;
            else if (hz)   exp_ctl = 6'b001100;
            else           exp_ctl = {4'b0000, iss, 1'b0};
            exp_ctl[0] = rst ? 1'b0 : m_busy;
            exp_ss = (m_stall > 7) ? 7 : m_stall;
            exp_sf = (m_flush > 7) ? 7 : m_flush;

            #2;
            n_chk++;
            if (w_ctl !== exp_ctl) $display("FAIL rnd_ctl n%0d got %b exp %b", n, w_ctl, exp_ctl);
            else n_pass++;
            n_chk++;
            if ({o_stall_cnt, o_flush_cnt} !== {32'(m_stall), 32'(m_flush)})
                $display("FAIL rnd_cnt n%0d got %0d %0d exp %0d %0d", n, o_stall_cnt, o_flush_cnt, m_stall, m_flush);
            else n_pass++;
            n_chk++;
            if ({s_stall_cnt, s_flush_cnt} !== {3'(exp_ss), 3'(exp_sf)})
                $display("FAIL rnd_sat n%0d got %0d %0d exp %0d %0d", n, s_stall_cnt, s_flush_cnt, exp_ss, exp_sf);
            else n_pass++;

            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_cnt[r] = 0;
                    m_lng[r] = 1'b0;
                end
                m_busy = 1'b0; m_stall = 0; m_flush = 0;
            end else begin
                if (hz && !br) m_stall++;
                if (br) m_flush++;
                for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
                if (dn) begin
                    if (lrd != 0) m_lng[lrd] = 1'b0;
                    m_busy = 1'b0;
                end
                if (iss && wr && rd != 0) begin
                    if (lg) begin
                        m_lng[rd] = 1'b1;
                        m_busy    = 1'b1;
                    end else begin
                        m_cnt[rd] = lat;
                    end
                end
            end
            tick;
        end
        i_reset = 1'b0;
        idle;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tick;
        test_reset;
        test_fixed_latency;
        test_x0_and_lui;
        test_long_op;
        test_back_to_back_long;
        test_branch_flush;
        test_reset_mid_and_sat;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
